alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Round-robin arbiter and sequencer that shares the single 17-bit ALU between two requesters: requester 0 is the pipeline EX stage, requester 1 is the coprocessor/debug port.
- Drives the ALU operand, func and shamt inputs and samples its combinational result and flags.
- Returns a registered result with a per-requester valid pulse.
- Holds operands stable for MUL, which needs MUL_LAT cycles to settle.

Parameters:
- MUL_LAT, 3: cycles MUL occupies the ALU from grant to result capture; legal 1..15; 1 means MUL is treated as a single-cycle op.
- CNT_W, 4: width of the hold counter; must satisfy 2^CNT_W > MUL_LAT.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- req0, req1  in  1  requester wants the ALU this cycle
- func0, func1  in  4  ALU func code; encoding per common_params.inc
- srca0, srca1  in  17  operand routed to ALU src0
- srcb0, srcb1  in  17  operand routed to ALU src1
- shamt0, shamt1  in  4  shift amount
- gnt0, gnt1  out  1  combinational grant; the op is accepted on any edge where req_i && gnt_i
- alu_src0, alu_src1  out  17  to ALU
- alu_func  out  4  to ALU
- alu_shamt  out  4  to ALU
- alu_dst  in  17  combinational ALU result
- alu_ov, alu_zr, alu_neg  in  1  ALU flags
- rslt  out  17  registered result of the last completed op
- rslt_ov, rslt_zr, rslt_neg  out  1  registered flags captured with rslt
- vld0, vld1  out  1  one-cycle pulse: rslt belongs to requester i
- busy  out  1  high in HOLD state

Behaviour:
- Reset (async, immediate): state=IDLE, last=1 (requester 0 wins first), cnt=0, rslt=0, flags=0, vld0=vld1=0, operand latches=0. A MUL in progress is discarded and no vld is issued for it.
- States: IDLE and HOLD.
- IDLE, grants:
  - Winner = the only requester asserting req; if both assert, the requester != last.
  - gnt_winner=1, other gnt=0; no req gives no gnt.
  - ALU inputs are driven combinationally from the winner's func/srca/srcb/shamt.
  - With no winner, ALU inputs are driven to 0 (func=4'h0).
- IDLE, accepted non-MUL op (or MUL with MUL_LAT==1):
  - On the edge, capture alu_dst and flags into rslt/rslt_*.
  - Pulse vld_winner=1 for the following cycle; set last=winner. Latency is 1 cycle.
  - Back-to-back accepts every cycle are legal (full throughput).
- IDLE, accepted MUL with MUL_LAT>1:
  - On the edge, latch func/operands/shamt and the owner ID, set cnt=MUL_LAT-1, go to HOLD, set last=winner.
  - No result is captured and no vld is issued on that edge.
- HOLD:
  - gnt0=gnt1=0 regardless of req; requesters keep req high and wait.
  - ALU inputs are driven from the latches.
  - Each edge, cnt decrements. On the edge where cnt==1: capture alu_dst/flags, pulse vld_owner next cycle, go to IDLE.
  - Result appears MUL_LAT cycles after the grant edge.
- vld is never asserted for both requesters in the same cycle.
- rslt holds its value until the next capture.
- Between captures, vld is 0 and rslt is stable.
- Dropping req while granted in IDLE simply means no accept; no state change.
- A requester cannot cancel a MUL once it is in HOLD.
- Width rules: all data is passed through unmodified at 17 bits; the arbiter performs no arithmetic other than cnt.

Test Plan:
- Reset, then req0 only: func=ADD, srca0=17'h0003, srcb0=17'h0004 -> gnt0=1 same cycle; next cycle vld0=1, rslt=17'h0007, rslt_zr=0.
- req0 and req1 held high for 4 cycles, both ADD of 1+1 and 2+2 -> grants alternate 0,1,0,1; vld0/vld1 alternate; rslt alternates 2,4.
- req1 MUL 17'h0003 x 17'h0005, MUL_LAT=3, req0 also high -> gnt1 at cycle T; busy in T+1..T+2; gnt0=0 during HOLD; alu_src* stable; vld1 at T+3 with rslt=17'h000F; gnt0=1 at T+3.
- SUB 17'h0005 minus 17'h0005 via req0 -> rslt=0, rslt_zr=1, rslt_neg=0; next SUB 1-2 -> rslt_neg=1.
- Assert rst during HOLD of a MUL -> vld0=vld1=0 immediately and no later vld; busy=0; the next accept with both req high is granted to requester 0.
- MUL_LAT=1 build, MUL 2x3 -> single-cycle: vld next cycle, rslt=17'h0006, busy never asserts.

Source files
------------

// File: rtl/alu_share_arb.sv
// ============================================================================
//  Module   : alu_share_arb
//  Purpose  : Round-robin arbiter/sequencer sharing one 17-bit ALU between the
//             EX stage (requester 0) and the coprocessor/debug port (1).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arb #(
   parameter int         MUL_LAT  = 3,
   parameter int         CNT_W    = 4,
   parameter logic [3:0] MUL_FUNC = 4'h3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic [3:0]  func0,
   input  logic [3:0]  func1,
   input  logic [16:0] srca0,
   input  logic [16:0] srca1,
   input  logic [16:0] srcb0,
   input  logic [16:0] srcb1,
   input  logic [3:0]  shamt0,
   input  logic [3:0]  shamt1,
   output logic        gnt0,
   output logic        gnt1,
   output logic [16:0] alu_src0,
   output logic [16:0] alu_src1,
   output logic [3:0]  alu_func,
   output logic [3:0]  alu_shamt,
   input  logic [16:0] alu_dst,
   input  logic        alu_ov,
   input  logic        alu_zr,
   input  logic        alu_neg,
   output logic [16:0] rslt,
   output logic        rslt_ov,
   output logic        rslt_zr,
   output logic        rslt_neg,
   output logic        vld0,
   output logic        vld1,
   output logic        busy
);

   localparam bit             c_mul_multi = (MUL_LAT > 1);
   localparam logic [CNT_W-1:0] c_hold_init = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic              r_last;
   logic              r_owner;
   logic [CNT_W-1:0]  r_cnt;
   logic [3:0]        r_func;
   logic [16:0]       r_srca;
   logic [16:0]       r_srcb;
   logic [3:0]        r_shamt;

   logic              w_accept;
   logic              w_win;
   logic              w_mul_start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_win       = 1'b0;
      w_mul_start = 1'b0;
      gnt0        = 1'b0;
      gnt1        = 1'b0;
      busy        = 1'b0;
      alu_src0    = '0;
      alu_src1    = '0;
      alu_func    = 4'h0;
      alu_shamt   = 4'h0;
      case (r_state)
         IDLE: begin
            if (req0 || req1) begin
               w_accept = 1'b1;
               // On contention, the requester that did not win last goes next.
               w_win    = (req0 && req1) ? ~r_last : req1;
               gnt0     = ~w_win;
               gnt1     = w_win;
               if (w_win) begin
                  alu_src0  = srca1;
                  alu_src1  = srcb1;
                  alu_func  = func1;
                  alu_shamt = shamt1;
               end else begin
                  alu_src0  = srca0;
                  alu_src1  = srcb0;
                  alu_func  = func0;
                  alu_shamt = shamt0;
               end
               w_mul_start = c_mul_multi && (alu_func == MUL_FUNC);
               if (w_mul_start) begin
                  w_state_nxt = HOLD;
               end
            end
         end
         HOLD: begin
            busy      = 1'b1;
            alu_src0  = r_srca;
            alu_src1  = r_srcb;
            alu_func  = r_func;
            alu_shamt = r_shamt;
            if (r_cnt == c_cnt_one) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last   <= 1'b1;
         r_owner  <= 1'b0;
         r_cnt    <= '0;
         r_func   <= 4'h0;
         r_srca   <= '0;
         r_srcb   <= '0;
         r_shamt  <= 4'h0;
         rslt     <= '0;
         rslt_ov  <= 1'b0;
         rslt_zr  <= 1'b0;
         rslt_neg <= 1'b0;
         vld0     <= 1'b0;
         vld1     <= 1'b0;
      end else begin
         vld0 <= 1'b0;
         vld1 <= 1'b0;
         if (r_state == IDLE) begin
            if (w_accept) begin
               r_last <= w_win;
               if (w_mul_start) begin
                  // Freeze the operands so the multiplier sees a stable input.
                  r_owner <= w_win;
                  r_cnt   <= c_hold_init;
                  r_func  <= alu_func;
                  r_srca  <= alu_src0;
                  r_srcb  <= alu_src1;
                  r_shamt <= alu_shamt;
               end else begin
                  rslt     <= alu_dst;
                  rslt_ov  <= alu_ov;
                  rslt_zr  <= alu_zr;
                  rslt_neg <= alu_neg;
                  vld0     <= ~w_win;
                  vld1     <= w_win;
               end
            end
         end else begin
            r_cnt <= r_cnt - c_cnt_one;
            if (r_cnt == c_cnt_one) begin
               rslt     <= alu_dst;
               rslt_ov  <= alu_ov;
               rslt_zr  <= alu_zr;
               rslt_neg <= alu_neg;
               vld0     <= ~r_owner;
               vld1     <= r_owner;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arb.sv
// ============================================================================
//  Module   : tb_alu_share_arb
//  Purpose  : Self-checking bench for alu_share_arb (MUL_LAT=3 and MUL_LAT=1).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_share_arb;

   localparam logic [3:0] F_ADD = 4'h1;
   localparam logic [3:0] F_SUB = 4'h2;
   localparam logic [3:0] F_MUL = 4'h3;
   localparam logic [3:0] F_AND = 4'h4;
   localparam logic [3:0] F_SHL = 4'h5;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1;
   logic [3:0]  func0, func1, shamt0, shamt1;
   logic [16:0] srca0, srca1, srcb0, srcb1;

   logic        gnt0, gnt1, vld0, vld1, busy;
   logic [16:0] alu_src0, alu_src1, alu_dst, rslt;
   logic [3:0]  alu_func, alu_shamt;
   logic        alu_ov, alu_zr, alu_neg, rslt_ov, rslt_zr, rslt_neg;

   logic        gnt0_s, gnt1_s, vld0_s, vld1_s, busy_s;
   logic [16:0] alu_src0_s, alu_src1_s, alu_dst_s, rslt_s;
   logic [3:0]  alu_func_s, alu_shamt_s;
   logic        alu_ov_s, alu_zr_s, alu_neg_s, rslt_ov_s, rslt_zr_s, rslt_neg_s;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // Reference ALU: returns {ov, zr, neg, dst}
   function automatic logic [19:0] alu_fn(input logic [3:0] f, input logic [16:0] a,
                                          input logic [16:0] b, input logic [3:0] sh);
      logic [16:0] d;
      logic [33:0] p;
      logic        ov;
      d  = '0;
      ov = 1'b0;
      p  = 34'(a) * 34'(b);
      case (f)
         F_ADD: begin d = a + b; ov = (a[16] == b[16]) && (d[16] != a[16]); end
         F_SUB: begin d = a - b; ov = (a[16] != b[16]) && (d[16] != a[16]); end
         F_MUL: d = p[16:0];
         F_AND: d = a & b;
         F_SHL: d = a << sh;
         default: d = '0;
      endcase
      return {ov, (d == 17'h0), d[16], d};
   endfunction

   assign {alu_ov, alu_zr, alu_neg, alu_dst} = alu_fn(alu_func, alu_src0, alu_src1, alu_shamt);
   assign {alu_ov_s, alu_zr_s, alu_neg_s, alu_dst_s} =
          alu_fn(alu_func_s, alu_src0_s, alu_src1_s, alu_shamt_s);

   alu_share_arb #(.MUL_LAT(3), .CNT_W(4), .MUL_FUNC(F_MUL)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1),
      .func0(func0), .func1(func1), .srca0(srca0), .srca1(srca1),
      .srcb0(srcb0), .srcb1(srcb1), .shamt0(shamt0), .shamt1(shamt1),
      .gnt0(gnt0), .gnt1(gnt1), .alu_src0(alu_src0), .alu_src1(alu_src1),
      .alu_func(alu_func), .alu_shamt(alu_shamt), .alu_dst(alu_dst),
      .alu_ov(alu_ov), .alu_zr(alu_zr), .alu_neg(alu_neg),
      .rslt(rslt), .rslt_ov(rslt_ov), .rslt_zr(rslt_zr), .rslt_neg(rslt_neg),
      .vld0(vld0), .vld1(vld1), .busy(busy)
   );

   alu_share_arb #(.MUL_LAT(1), .CNT_W(4), .MUL_FUNC(F_MUL)) dut_s (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1),
      .func0(func0), .func1(func1), .srca0(srca0), .srca1(srca1),
      .srcb0(srcb0), .srcb1(srcb1), .shamt0(shamt0), .shamt1(shamt1),
      .gnt0(gnt0_s), .gnt1(gnt1_s), .alu_src0(alu_src0_s), .alu_src1(alu_src1_s),
      .alu_func(alu_func_s), .alu_shamt(alu_shamt_s), .alu_dst(alu_dst_s),
      .alu_ov(alu_ov_s), .alu_zr(alu_zr_s), .alu_neg(alu_neg_s),
      .rslt(rslt_s), .rslt_ov(rslt_ov_s), .rslt_zr(rslt_zr_s), .rslt_neg(rslt_neg_s),
      .vld0(vld0_s), .vld1(vld1_s), .busy(busy_s)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: expected results queued on accept, popped on vld
   typedef struct packed {
      logic        owner;
      logic [16:0] r;
      logic        ov;
      logic        zr;
      logic        neg;
   } exp_t;

   exp_t q[$];
   exp_t sb_e;

   function automatic exp_t mk(input logic o, input logic [3:0] f, input logic [16:0] a,
                               input logic [16:0] b, input logic [3:0] sh);
      logic [19:0] r;
      r = alu_fn(f, a, b, sh);
      return {o, r[16:0], r[19], r[18], r[17]};
   endfunction

   always @(posedge rst) q.delete();

   always @(negedge clk) begin
      if (!rst) begin
         if (vld0 || vld1) begin
            check("vld_onehot", 32'(vld0 & vld1), 32'd0);
            if (q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL sb_unexpected_vld: got vld0=%0b vld1=%0b, expected no vld", vld0, vld1);
            end else begin
               sb_e = q.pop_front();
               check("sb_owner", 32'(vld1), 32'(sb_e.owner));
               check("sb_rslt", 32'(rslt), 32'(sb_e.r));
               check("sb_flags", 32'({rslt_ov, rslt_zr, rslt_neg}),
                     32'({sb_e.ov, sb_e.zr, sb_e.neg}));
            end
         end
         if (req0 && gnt0) q.push_back(mk(1'b0, func0, srca0, srcb0, shamt0));
         if (req1 && gnt1) q.push_back(mk(1'b1, func1, srca1, srcb1, shamt1));
      end
   end

   typedef struct {
      logic [3:0]  f;
      logic [16:0] a;
      logic [16:0] b;
      logic [3:0]  sh;
      logic [16:0] er;
      logic        eov;
      logic        ezr;
      logic        eneg;
   } vec_t;

   vec_t tbl[7];

   initial begin
      tbl[0] = '{F_ADD, 17'h00003, 17'h00004, 4'h0, 17'h00007, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{F_SUB, 17'h00005, 17'h00005, 4'h0, 17'h00000, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{F_SUB, 17'h00001, 17'h00002, 4'h0, 17'h1FFFF, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{F_ADD, 17'h0FFFF, 17'h00001, 4'h0, 17'h10000, 1'b1, 1'b0, 1'b1};
      tbl[4] = '{F_ADD, 17'h1FFFF, 17'h00001, 4'h0, 17'h00000, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{F_AND, 17'h1F0F0, 17'h0FF00, 4'h0, 17'h0F000, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{F_SHL, 17'h00001, 17'h00000, 4'h4, 17'h00010, 1'b0, 1'b0, 1'b0};

      rst = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      func0 = 4'h0; func1 = 4'h0; shamt0 = 4'h0; shamt1 = 4'h0;
      srca0 = '0; srca1 = '0; srcb0 = '0; srcb1 = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("rst_rslt", 32'(rslt), 32'd0);
      check("rst_flags", 32'({rslt_ov, rslt_zr, rslt_neg}), 32'd0);
      check("rst_vld", 32'({vld0, vld1}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_gnt_noreq", 32'({gnt0, gnt1}), 32'd0);
      check("idle_alu_zero", 32'({alu_func, alu_src0}), 32'd0);

      // Both requesters held high: grants alternate starting with requester 0
      @(posedge clk); #1;
      req0 = 1'b1; func0 = F_ADD; srca0 = 17'd1; srcb0 = 17'd1;
      req1 = 1'b1; func1 = F_ADD; srca1 = 17'd2; srcb1 = 17'd2;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("alt_gnt0", 32'(gnt0), 32'(i % 2 == 0));
         check("alt_gnt1", 32'(gnt1), 32'(i % 2 == 1));
         check("alt_src0", 32'(alu_src0), (i % 2 == 0) ? 32'd1 : 32'd2);
         if (i > 0) begin
            check("alt_vld0", 32'(vld0), 32'((i - 1) % 2 == 0));
            check("alt_rslt", 32'(rslt), ((i - 1) % 2 == 0) ? 32'd2 : 32'd4);
         end
      end
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      check("alt_last_vld1", 32'(vld1), 32'd1);
      check("alt_last_rslt", 32'(rslt), 32'd4);

      // Single-cycle ops through requester 0
      for (int k = 0; k < 7; k++) begin
         @(posedge clk); #1;
         req0 = 1'b1; func0 = tbl[k].f; srca0 = tbl[k].a; srcb0 = tbl[k].b; shamt0 = tbl[k].sh;
         @(negedge clk);
         check("tbl_gnt", 32'({gnt0, gnt1}), 32'b10);
         check("tbl_alu_in", 32'({alu_func, alu_src0}), 32'({tbl[k].f, tbl[k].a}));
         check("tbl_alu_b", 32'(alu_src1), 32'(tbl[k].b));
         @(posedge clk); #1;
         req0 = 1'b0;
         @(negedge clk);
         check("tbl_vld", 32'({vld0, vld1}), 32'b10);
         check("tbl_rslt", 32'(rslt), 32'(tbl[k].er));
         check("tbl_flags", 32'({rslt_ov, rslt_zr, rslt_neg}),
               32'({tbl[k].eov, tbl[k].ezr, tbl[k].eneg}));
      end
      shamt0 = 4'h0;
      @(negedge clk);
      check("hold_rslt_stable", 32'(rslt), 32'h10);
      check("hold_vld_low", 32'({vld0, vld1}), 32'd0);

      // MUL via requester 1 while requester 0 waits
      @(posedge clk); #1;
      req0 = 1'b1; func0 = F_ADD; srca0 = 17'd2; srcb0 = 17'd2;
      req1 = 1'b1; func1 = F_MUL; srca1 = 17'h3; srcb1 = 17'h5;
      @(negedge clk);
      check("mul_gnt", 32'({gnt0, gnt1}), 32'b01);
      check("mul_busy_t", 32'(busy), 32'd0);
      @(posedge clk); #1;
      req1 = 1'b0; srca1 = 17'h1ABCD; srcb1 = 17'h12345;
      for (int j = 1; j < 3; j++) begin
         @(negedge clk);
         check("mul_busy", 32'(busy), 32'd1);
         check("mul_gnt_hold", 32'({gnt0, gnt1}), 32'd0);
         check("mul_src_stable", 32'({alu_src0, alu_src1}), 32'({17'h3, 17'h5}));
         check("mul_func_stable", 32'(alu_func), 32'(F_MUL));
         check("mul_no_vld", 32'({vld0, vld1}), 32'd0);
      end
      @(negedge clk);
      check("mul_vld1", 32'({vld0, vld1}), 32'b01);
      check("mul_rslt", 32'(rslt), 32'h0000F);
      check("mul_gnt0_after", 32'(gnt0), 32'd1);
      check("mul_busy_clr", 32'(busy), 32'd0);
      @(posedge clk); #1;
      req0 = 1'b0;
      @(negedge clk);
      check("post_mul_vld0", 32'(vld0), 32'd1);
      check("post_mul_rslt", 32'(rslt), 32'd4);

      // Reset during HOLD discards the MUL
      @(posedge clk); #1;
      req1 = 1'b1; func1 = F_MUL; srca1 = 17'h3; srcb1 = 17'h5;
      @(negedge clk);
      check("rstmul_gnt1", 32'(gnt1), 32'd1);
      @(posedge clk); #1;
      req1 = 1'b0;
      @(negedge clk);
      check("rstmul_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rstmul_busy_clr", 32'(busy), 32'd0);
      check("rstmul_vld_clr", 32'({vld0, vld1}), 32'd0);
      check("rstmul_rslt_clr", 32'(rslt), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check("rstmul_no_vld", 32'({vld0, vld1}), 32'd0);
      end
      @(posedge clk); #1;
      req0 = 1'b1; func0 = F_ADD; srca0 = 17'd1; srcb0 = 17'd1;
      req1 = 1'b1; func1 = F_ADD; srca1 = 17'd2; srcb1 = 17'd2;
      @(negedge clk);
      check("rstmul_first_gnt", 32'({gnt0, gnt1}), 32'b10);
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      check("rstmul_vld0", 32'({vld0, vld1}), 32'b10);
      check("rstmul_rslt", 32'(rslt), 32'd2);

      // MUL_LAT=1 instance: MUL completes in one cycle
      @(posedge clk); #1;
      req0 = 1'b1; func0 = F_MUL; srca0 = 17'd2; srcb0 = 17'd3;
      @(negedge clk);
      check("lat1_gnt0", 32'(gnt0_s), 32'd1);
      check("lat1_busy_t", 32'(busy_s), 32'd0);
      @(posedge clk); #1;
      req0 = 1'b0;
      @(negedge clk);
      check("lat1_vld0", 32'({vld0_s, vld1_s}), 32'b10);
      check("lat1_rslt", 32'(rslt_s), 32'h00006);
      check("lat1_busy", 32'(busy_s), 32'd0);
      @(negedge clk);
      check("lat1_vld_pulse", 32'({vld0_s, vld1_s}), 32'd0);
      check("lat1_busy_after", 32'(busy_s), 32'd0);

      repeat (4) @(negedge clk);
      check("sb_drained", 32'(q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
